// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// State enum, instruction field codes, ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        WB_R   = 4'd3,
        EXEC_I = 4'd4,
        WB_I   = 4'd5,
        ADDR   = 4'd6,
        MEM_RD = 4'd7,
        MEM_WB = 4'd8,
        MEM_WR = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam int ALU_OP_W = 4;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'd7;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational instruction decode: ALU operation, immediate extension mode and legality.
// Branch/jump opcodes are only legal when BRANCH_EN is set.
module mc_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int BRANCH_EN = 1
) (
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                ext_zero,
    output logic                legal
);

    always_comb begin
        alu_op   = ALU_ADD;
        ext_zero = 1'b0;
        legal    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                legal = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    default: legal  = 1'b0;
                endcase
            end
            OP_ADDI: legal = 1'b1;
            OP_ANDI: begin alu_op = ALU_AND; ext_zero = 1'b1; legal = 1'b1; end
            OP_ORI:  begin alu_op = ALU_OR;  ext_zero = 1'b1; legal = 1'b1; end
            OP_XORI: begin alu_op = ALU_XOR; ext_zero = 1'b1; legal = 1'b1; end
            OP_LUI:  begin alu_op = ALU_LUI; ext_zero = 1'b1; legal = 1'b1; end
            OP_LW, OP_SW: legal = 1'b1;
            OP_BEQ, OP_BNE: begin
                alu_op = ALU_SUB;
                legal  = (BRANCH_EN != 0);
            end
            OP_J:    legal = (BRANCH_EN != 0);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control unit: registered state, Moore decode of state plus IR fields.
// All outputs are forced low while rst_n is asserted so no enable survives a reset.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_WAIT_EN = 1,
    parameter int BRANCH_EN   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic                  ext_zero,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  illegal,
    output logic [3:0]            state_o
);

    state_t              state;
    logic                rdy;
    logic [ALU_OP_W-1:0] dec_op;
    logic                dec_ext;
    logic                dec_legal;
    logic [ALU_OP_W-1:0] alu_op;

    assign rdy     = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
    assign state_o = state;

    mc_alu_dec #(.BRANCH_EN(BRANCH_EN)) u_dec (
        .opcode   (opcode),
        .funct    (funct),
        .alu_op   (dec_op),
        .ext_zero (dec_ext),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:  if (rdy) state <= DECODE;
                DECODE: begin
                    if (!dec_legal) begin
                        state <= FETCH;
                    end else begin
                        case (opcode)
                            OP_RTYPE:                               state <= EXEC_R;
                            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state <= EXEC_I;
                            OP_LW, OP_SW:                           state <= ADDR;
                            OP_BEQ, OP_BNE:                         state <= BRANCH;
                            OP_J:                                   state <= JUMP;
                            default:                                state <= FETCH;
                        endcase
                    end
                end
                EXEC_R: state <= WB_R;
                EXEC_I: state <= WB_I;
                ADDR:   state <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD: if (rdy) state <= MEM_WB;
                MEM_WR: if (rdy) state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PCSRC_ALU;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        ext_zero   = 1'b0;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = rdy;
                    pc_write  = rdy;
                end
                DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    illegal   = ~dec_legal;
                end
                EXEC_R: begin
                    alu_src_a = (funct == FN_SLL || funct == FN_SRL) ? SRCA_SHAMT : SRCA_REG;
                    alu_op    = dec_op;
                end
                WB_R: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                EXEC_I: begin
                    alu_src_a = SRCA_REG;
                    alu_src_b = SRCB_IMM;
                    alu_op    = dec_op;
                    ext_zero  = dec_ext;
                end
                // The ALU result is still being written back, so keep its controls steady.
                WB_I: begin
                    reg_write = 1'b1;
                    alu_op    = dec_op;
                    ext_zero  = dec_ext;
                end
                ADDR: begin
                    alu_src_a = SRCA_REG;
                    alu_src_b = SRCB_IMM;
                end
                MEM_RD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                MEM_WR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                BRANCH: begin
                    alu_src_a = SRCA_REG;
                    alu_op    = ALU_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
                end
                JUMP: begin
                    pc_src   = PCSRC_JUMP;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign alu_ctrl = ALU_CTRL_W'(alu_op);

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Clocked multicycle MIPS control unit. It drives the shared-datapath control lines (PC, IR, memory, register file, ALU muxes, ALU op) from a registered state machine. Compared with the earlier combinational controller, it adds branch/jump, memory wait-state handshaking, illegal-instruction detection and a parametrised ALU-control width. It sits between the instruction register (opcode/funct inputs) and the multicycle datapath.

Parameters:
ALU_CTRL_W, 4, width of alu_ctrl; must be >= 4.
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = mem_ready is treated as constant 1.
BRANCH_EN, 1, 1 = decode BEQ/BNE/J; 0 = those opcodes are illegal.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; stable from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
pc_write  out  1  PC load enable
pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
iord  out  1  memory address: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load enable
reg_dst  out  1  1 rd, 0 rt
mem_to_reg  out  1  1 MDR, 0 ALUOut
reg_write  out  1  register-file write enable
alu_src_a  out  2  00 PC, 01 A, 10 shamt
alu_src_b  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
ext_zero  out  1  1 zero-extend imm, 0 sign-extend
alu_ctrl  out  ALU_CTRL_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 LUI; upper bits 0
illegal  out  1  one-cycle pulse on an undecodable instruction
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset: state = FETCH; every output is 0 while rst_n is low, except state_o = FETCH.
- State register only; outputs are a Moore decode of state plus opcode/funct. Unlisted outputs are 0.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, ADD.
  - ir_write and pc_write are asserted only when mem_ready=1; the state then goes to DECODE. Otherwise the FSM holds in FETCH.
- DECODE: alu_src_a=00, alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
  - 000000 with funct in {100000,100010,100100,100101,100110,000000,000010} -> EXEC_R
  - 001000/001100/001101/001110/001111 -> EXEC_I
  - 100011/101011 -> ADDR
  - 000100/000101 -> BRANCH
  - 000010 -> JUMP
  - anything else -> FETCH with illegal=1 for this cycle.
- EXEC_R: alu_src_b=00; alu_src_a=10 for SLL/SRL, else 01; alu_ctrl from funct. Next WB_R.
- WB_R: reg_dst=1, reg_write=1, mem_to_reg=0. Next FETCH.
- EXEC_I: alu_src_a=01, alu_src_b=10.
  - ADDI uses ADD with sign extension.
  - ANDI/ORI/XORI use AND/OR/XOR with ext_zero=1.
  - LUI uses LUI with ext_zero=1.
  - Next WB_I.
- WB_I: reg_dst=0, reg_write=1, mem_to_reg=0; alu_ctrl/ext_zero are held. Next FETCH.
- ADDR: alu_src_a=01, alu_src_b=10, ADD, sign extension. LW -> MEM_RD; SW -> MEM_WR.
- MEM_RD: iord=1, mem_read=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1. Next FETCH.
- MEM_WR: iord=1, mem_write=1 held while waiting. Goes to FETCH on mem_ready.
- BRANCH: alu_src_a=01, alu_src_b=00, SUB, pc_src=01.
  - pc_write = zero for BEQ, ~zero for BNE.
  - Next FETCH.
- JUMP: pc_src=10, pc_write=1. Next FETCH.
- Base latency excluding wait cycles:
  - R-type / I-ALU / SW: 4 cycles
  - LW: 5 cycles
  - BEQ/BNE/J: 3 cycles
  - Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- Async reset mid-instruction aborts the instruction immediately; no write enable may be high during or after the reset edge.
- mem_write and reg_write are never high in the same cycle.
- ir_write is high only in FETCH.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum (4-bit): FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP
  - opcode/funct localparams
  - ALU op codes
  - alu_src_a/alu_src_b/pc_src encodings
- One sub-module, mc_alu_dec: combinational mapping of opcode/funct to alu_ctrl, ext_zero and a legal flag; it is reused by EXEC_R, EXEC_I and DECODE.

Test Plan:
- Reset held with mem_ready=1 -> all outputs 0, state_o=FETCH. Release -> FETCH: mem_read=1, alu_src_b=01, ir_write=1, pc_write=1.
- ADD (opcode 0, funct 100000), mem_ready=1 -> states FETCH, DECODE, EXEC_R, WB_R. WB_R: reg_write=1, reg_dst=1. Next instruction fetch at cycle 5.
- LW (100011), mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles with iord=1, then MEM_WB with mem_to_reg=1, reg_write=1. 7 cycles total.
- BEQ with zero=1 -> BRANCH: pc_src=01, pc_write=1. With zero=0 -> pc_write=0. BNE gives the inverse result.
- Opcode 111111 -> illegal=1 for exactly one cycle in DECODE, no write enables asserted, back to FETCH. BRANCH_EN=0 with opcode 000100 behaves the same.
- ORI (001101) -> EXEC_I: alu_ctrl=3, ext_zero=1, alu_src_b=10. Then rst_n pulsed low in WB_I -> reg_write drops immediately, FSM restarts in FETCH.
